// File: rtl/exe_stage_if.sv
// exe_stage_if -- ID/EXE inputs and EXE/MEM outputs of the execute stage.
//
// Ports (signals of the bundle):
//   ewreg, em2reg, ewmem  ID/EXE control bits
//   ealuc[3:0]            ALU operation
//   ealuimm               1 = B operand is eimm32, 0 = B operand is eqb
//   edestReg[4:0]         destination register
//   eqa, eqb, eimm32      32-bit operands
//   mwreg, mm2reg, mwmem  registered EXE/MEM control
//   mdestReg[4:0]         registered destination
//   mr[31:0]              registered ALU/MUL result
//   mqb[31:0]             registered store data
//   stall                 hold request back to the ID stage
//
// Flow control: there is no valid/ready pair. The ID/EXE side presents one
// instruction per cycle; while stall=1 it must hold every e* input and the PC
// unchanged, and the execute stage loads a bubble (no write, no store) into
// EXE/MEM on each such edge. A cycle with stall=0 consumes the presented
// instruction on the next rising edge.
//
// modport master: drives the e* inputs (ID/EXE side or testbench)
// modport slave : the execute stage itself
interface exe_stage_if;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic [4:0]  edestReg;
  logic [31:0] eqa;
  logic [31:0] eqb;
  logic [31:0] eimm32;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [4:0]  mdestReg;
  logic [31:0] mr;
  logic [31:0] mqb;
  logic        stall;

  modport master (
    output ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
    input  mwreg, mm2reg, mwmem, mdestReg, mr, mqb, stall
  );

  modport slave (
    input  ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
    output mwreg, mm2reg, mwmem, mdestReg, mr, mqb, stall
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage -- pipeline execute stage: ALU, optional sequential multiplier,
// and the EXE/MEM pipeline register.
//
// Ports:
//   clock      rising-edge clock
//   clrn       asynchronous active-low reset
//   bus        exe_stage_if.slave (ID/EXE inputs, EXE/MEM outputs, stall)
//   fsm_state  debug view of the multiplier FSM (0 = IDLE, 1 = BUSY, 2 = DONE);
//              constant 0 when the multiplier is not built
//
// Build option: define EXE_MUL_EN to include the 32-step shift-add multiplier
// for ealuc=1111. Without it, 1111 behaves like any unused code (result 0) and
// stall is tied low.
module exe_stage (
  input  logic         clock,
  input  logic         clrn,
  exe_stage_if.slave   bus,
  output logic [1:0]   fsm_state
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_LUI  = 4'b1011;

  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic [4:0]  sa;
  logic [31:0] wb_r;       // value written into mr when the register loads
  logic        stall_int;

  // ALU: B is the immediate or eqb; shifts move B by A[4:0].
  always_comb begin
    alu_b = bus.ealuimm ? bus.eimm32 : bus.eqb;
    sa    = bus.eqa[4:0];
    alu_r = '0;
    case (bus.ealuc)
      OP_ADD:  alu_r = bus.eqa + alu_b;
      OP_SUB:  alu_r = bus.eqa - alu_b;
      OP_AND:  alu_r = bus.eqa & alu_b;
      OP_OR:   alu_r = bus.eqa | alu_b;
      OP_XOR:  alu_r = bus.eqa ^ alu_b;
      OP_NOR:  alu_r = ~(bus.eqa | alu_b);
      OP_SLT:  alu_r = {31'd0, $signed(bus.eqa) < $signed(alu_b)};
      OP_SLTU: alu_r = {31'd0, bus.eqa < alu_b};
      OP_SLL:  alu_r = alu_b << sa;
      OP_SRL:  alu_r = alu_b >> sa;
      OP_SRA:  alu_r = $unsigned($signed(alu_b) >>> sa);
      OP_LUI:  alu_r = {alu_b[15:0], 16'd0};
      default: alu_r = '0;
    endcase
  end

`ifdef EXE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1111;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] mul_a;      // multiplicand, shifted left each step
  logic [31:0] mul_b;      // multiplier, shifted right each step
  logic [31:0] mul_acc;    // low 32 bits of the partial product
  logic        is_mul;

  assign is_mul = (bus.ealuc == OP_MUL);

  // Reset overrides the request so the ID stage is never held while clrn=0.
  assign stall_int = clrn & (((state == S_IDLE) & is_mul) | (state == S_BUSY));
  assign wb_r      = (state == S_DONE) ? mul_acc : alu_r;
  assign fsm_state = state;

  // Inputs are only looked at in IDLE; BUSY works purely on latched operands.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mul) begin
            mul_a   <= bus.eqa;
            mul_b   <= alu_b;
            mul_acc <= '0;
            cnt     <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mul_b[0]) mul_acc <= mul_acc + mul_a;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 6'd1;
          // cnt counts completed steps; this edge completes step 32.
          if (cnt == 6'd31) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign stall_int = 1'b0;
  assign wb_r      = alu_r;
  assign fsm_state = 2'd0;
`endif

  // EXE/MEM pipeline register. A stalled edge inserts a bubble: the write and
  // memory enables drop while destination and data hold their old values.
  logic        mwreg_q, mm2reg_q, mwmem_q;
  logic [4:0]  mdest_q;
  logic [31:0] mr_q, mqb_q;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      mdest_q  <= '0;
      mr_q     <= '0;
      mqb_q    <= '0;
    end else if (stall_int) begin
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
    end else begin
      mwreg_q  <= bus.ewreg;
      mm2reg_q <= bus.em2reg;
      mwmem_q  <= bus.ewmem;
      mdest_q  <= bus.edestReg;
      mr_q     <= wb_r;
      mqb_q    <= bus.eqb;
    end
  end

  assign bus.mwreg    = mwreg_q;
  assign bus.mm2reg   = mm2reg_q;
  assign bus.mwmem    = mwmem_q;
  assign bus.mdestReg = mdest_q;
  assign bus.mr       = mr_q;
  assign bus.mqb      = mqb_q;
  assign bus.stall    = stall_int;

endmodule
